// File: rtl/lfsr_share_arbiter.sv
// lfsr_share_arbiter
//   Shares one Galois LFSR word source among NUM_REQ requesters. A round-robin arbiter
//   grants one requester per transfer over a valid/ready handshake. Every accepted
//   transfer advances the LFSR by one step, so no two grants see the same word. Seed
//   writes arriving while an offer is stalled are held as pending until that offer is
//   accepted, so a reload never changes a word already on offer.
//
// Optional build macro: LFSR_SHARE_WRAP_DET_EN
//   Defined   - a WIDTH+1-bit step counter is built, and wrap_pulse flags a step that
//               returns the LFSR to the last loaded seed.
//   Undefined - no counter is built; wrap_pulse is tied low.
//
// Ports
//   clk          in   clock, all state on rising edge
//   reset        in   synchronous, active-high reset
//   req          in   [NUM_REQ] level request per requester
//   seed_we      in   seed write strobe
//   seed_data    in   [WIDTH] seed value (zero is replaced by SEED)
//   out_ready    in   consumer accepts the current offer
//   out_valid    out  offer valid
//   out_gnt      out  [NUM_REQ] one-hot grant, zero when no offer
//   out_data     out  [WIDTH] offered LFSR word
//   seed_pending out  a seed is captured and waits for the current offer's accept
//   wrap_pulse   out  one-cycle pulse when a step reproduces the last loaded seed
module lfsr_share_arbiter #(
  parameter int unsigned      NUM_REQ = 4,
  parameter int unsigned      WIDTH   = 5,
  parameter logic [WIDTH-1:0] TAPS    = 5'h14,
  parameter logic [WIDTH-1:0] SEED    = 5'h01
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               seed_we,
  input  logic [WIDTH-1:0]   seed_data,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [NUM_REQ-1:0] out_gnt,
  output logic [WIDTH-1:0]   out_data,
  output logic               seed_pending,
  output logic               wrap_pulse
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [IdxW:0]   idx_ext_t;

  localparam idx_ext_t NumReqExt = idx_ext_t'(NUM_REQ);

  typedef struct packed {
    logic found;
    idx_t idx;
  } arb_t;

  typedef enum logic [0:0] {StIdle, StOffer} state_e;

  // First requester at or after ptr, wrapping around.
  function automatic arb_t arbitrate(input logic [NUM_REQ-1:0] r, input idx_t ptr);
    arb_t     res;
    idx_ext_t k;
    res = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = idx_ext_t'(ptr) + idx_ext_t'(i);
      if (k >= NumReqExt) k = k - NumReqExt;
      if (!res.found && r[k[IdxW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = k[IdxW-1:0];
      end
    end
    return res;
  endfunction

  function automatic idx_t next_ptr(input idx_t i);
    return (i == idx_t'(NUM_REQ - 1)) ? '0 : idx_t'(i + 1'b1);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input idx_t i);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] l);
    return (l >> 1) ^ (l[0] ? TAPS : '0);
  endfunction

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   lfsr_q, lfsr_d;
  logic [WIDTH-1:0]   last_seed_q, last_seed_d;
  idx_t               rr_ptr_q, rr_ptr_d;
  idx_t               gnt_idx_q, gnt_idx_d;
  logic [NUM_REQ-1:0] out_gnt_q, out_gnt_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               pend_q, pend_d;
  logic [WIDTH-1:0]   pend_seed_q, pend_seed_d;

  logic [WIDTH-1:0]   seed_fix;
  logic               accept;
  idx_t               ptr_acc;
  arb_t               arb_idle, arb_acc;

  // The LFSR must never hold zero; a zero write falls back to the reset seed.
  assign seed_fix = (seed_data == '0) ? SEED : seed_data;
  assign accept   = (state_q == StOffer) && out_ready;
  assign ptr_acc  = next_ptr(gnt_idx_q);

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    last_seed_d = last_seed_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_idx_d   = gnt_idx_q;
    out_gnt_d   = out_gnt_q;
    out_data_d  = out_data_q;
    pend_d      = pend_q;
    pend_seed_d = pend_seed_q;
    arb_idle    = arbitrate(req, rr_ptr_q);
    arb_acc     = arbitrate(req, ptr_acc);

    unique case (state_q)
      StIdle: begin
        if (seed_we) begin
          // Seed write wins over a request: no offer this cycle.
          lfsr_d      = seed_fix;
          last_seed_d = seed_fix;
        end else if (arb_idle.found) begin
          state_d    = StOffer;
          gnt_idx_d  = arb_idle.idx;
          out_gnt_d  = onehot(arb_idle.idx);
          out_data_d = lfsr_q;
        end
      end
      StOffer: begin
        if (out_ready) begin
          rr_ptr_d = ptr_acc;
          if (seed_we) begin
            // A fresh write beats both the step and any older pending seed.
            lfsr_d      = seed_fix;
            last_seed_d = seed_fix;
            pend_d      = 1'b0;
          end else if (pend_q) begin
            lfsr_d      = pend_seed_q;
            last_seed_d = pend_seed_q;
            pend_d      = 1'b0;
          end else begin
            lfsr_d = lfsr_step(lfsr_q);
          end
          if (arb_acc.found) begin
            gnt_idx_d  = arb_acc.idx;
            out_gnt_d  = onehot(arb_acc.idx);
            out_data_d = lfsr_d;
          end else begin
            state_d   = StIdle;
            out_gnt_d = '0;
          end
        end else if (seed_we) begin
          pend_d      = 1'b1;
          pend_seed_d = seed_fix;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      lfsr_q      <= SEED;
      last_seed_q <= SEED;
      rr_ptr_q    <= '0;
      gnt_idx_q   <= '0;
      out_gnt_q   <= '0;
      out_data_q  <= '0;
      pend_q      <= 1'b0;
      pend_seed_q <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      last_seed_q <= last_seed_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      out_gnt_q   <= out_gnt_d;
      out_data_q  <= out_data_d;
      pend_q      <= pend_d;
      pend_seed_q <= pend_seed_d;
    end
  end

  assign out_valid    = (state_q == StOffer);
  assign out_gnt      = out_gnt_q;
  assign out_data     = out_data_q;
  assign seed_pending = pend_q;

`ifdef LFSR_SHARE_WRAP_DET_EN
  localparam logic [WIDTH:0] CntSat = {1'b1, {WIDTH{1'b0}}};

  logic           load, step;
  logic [WIDTH:0] cnt_q, cnt_d;
  logic           wrap_q, wrap_d;

  assign load = ((state_q == StIdle) && seed_we) || (accept && (seed_we || pend_q));
  assign step = accept && !seed_we && !pend_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (step && (cnt_q != CntSat)) begin
      cnt_d = cnt_q + 1'b1;
    end
    // The first step after a load can never land back on the seed.
    wrap_d = step && (cnt_q != '0) && (lfsr_d == last_seed_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign wrap_pulse = wrap_q;
`else
  assign wrap_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_share_arbiter.sv
module tb_lfsr_share_arbiter;

  localparam int NR     = 4;
  localparam int W      = 5;
  localparam int Period = 31;
  localparam int SeedV  = 'h01;
`ifdef LFSR_SHARE_WRAP_DET_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req;
  logic          seed_we;
  logic [W-1:0]  seed_data;
  logic          out_ready;
  logic          out_valid;
  logic [NR-1:0] out_gnt;
  logic [W-1:0]  out_data;
  logic          seed_pending;
  logic          wrap_pulse;

  always #5 clk = ~clk;

  lfsr_share_arbiter #(
    .NUM_REQ (NR),
    .WIDTH   (W),
    .TAPS    (5'h14),
    .SEED    (5'h01)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .seed_we      (seed_we),
    .seed_data    (seed_data),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_gnt      (out_gnt),
    .out_data     (out_data),
    .seed_pending (seed_pending),
    .wrap_pulse   (wrap_pulse)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the LFSR is a position in its precomputed maximal-length cycle.
  int seq [Period];
  bit m_valid;
  int m_gidx;
  int m_data;
  bit m_pend;
  int m_pend_seed;
  int m_ptr;
  int m_pos;
  int m_last;
  bit m_wrap;

  function automatic int pos_of(input int s);
    for (int i = 0; i < Period; i++) if (seq[i] == s) return i;
    return 0;
  endfunction

  function automatic int fix(input int s);
    return (s == 0) ? SeedV : s;
  endfunction

  function automatic int arb(input logic [NR-1:0] r, input int ptr);
    for (int i = 0; i < NR; i++) if (r[(ptr + i) % NR]) return (ptr + i) % NR;
    return 0;
  endfunction

  task automatic model_step();
    int s;
    m_wrap = 1'b0;
    if (reset) begin
      m_valid = 0; m_gidx = 0; m_data = 0; m_pend = 0; m_pend_seed = 0;
      m_ptr = 0; m_pos = pos_of(SeedV); m_last = SeedV;
    end else if (!m_valid) begin
      if (seed_we) begin
        s = fix(int'(seed_data)); m_pos = pos_of(s); m_last = s;
      end else if (req != 0) begin
        m_valid = 1; m_gidx = arb(req, m_ptr); m_data = seq[m_pos];
      end
    end else if (out_ready) begin
      m_ptr = (m_gidx + 1) % NR;
      if (seed_we) begin
        s = fix(int'(seed_data)); m_pos = pos_of(s); m_last = s; m_pend = 0;
      end else if (m_pend) begin
        m_pos = pos_of(m_pend_seed); m_last = m_pend_seed; m_pend = 0;
      end else begin
        m_pos = (m_pos + 1) % Period;
        m_wrap = WrapEn && (seq[m_pos] == m_last);
      end
      if (req != 0) begin
        m_gidx = arb(req, m_ptr); m_data = seq[m_pos];
      end else begin
        m_valid = 0;
      end
    end else if (seed_we) begin
      m_pend = 1; m_pend_seed = fix(int'(seed_data));
    end
  endtask

  task automatic compare(input string tag);
    check_eq({tag, "_valid"}, out_valid, m_valid);
    check_eq({tag, "_gnt"}, out_gnt, m_valid ? (1 << m_gidx) : 0);
    if (m_valid) check_eq({tag, "_data"}, out_data, m_data);
    check_eq({tag, "_pend"}, seed_pending, m_pend);
    check_eq({tag, "_wrap"}, wrap_pulse, m_wrap);
  endtask

  task automatic drive(input logic [NR-1:0] r, input logic we, input logic [W-1:0] sd,
                       input logic rdy);
    req = r; seed_we = we; seed_data = sd; out_ready = rdy;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive('0, 1'b0, '0, 1'b0);
    tick("rst");
    tick("rst");
    check_eq("rst_data", out_data, 0);
    reset = 1'b0;
  endtask

  int exp_data [5] = '{'h01, 'h14, 'h0a, 'h05, 'h16};
  int exp_gnt  [5] = '{'b0001, 'b0010, 'b0100, 'b1000, 'b0001};
  int wraps;

  initial begin
    int x;
    x = SeedV;
    for (int i = 0; i < Period; i++) begin
      seq[i] = x;
      x = (x >> 1) ^ (((x & 1) != 0) ? 'h14 : 0);
    end

    do_reset();

    // Single requester, always ready: one new word every cycle.
    drive(4'b0001, 1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick("t1");
      check_eq("t1_data", out_data, exp_data[i]);
      check_eq("t1_gnt", out_gnt, 4'b0001);
    end

    // All requesting: round-robin rotation.
    do_reset();
    drive(4'b1111, 1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick("t2");
      check_eq("t2_gnt", out_gnt, exp_gnt[i]);
      check_eq("t2_data", out_data, exp_data[i]);
    end

    // Stalled offer held stable after the request drops.
    do_reset();
    drive(4'b0010, 1'b0, '0, 1'b0);
    tick("t3");
    drive(4'b0000, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick("t3");
      check_eq("t3_hold_gnt", out_gnt, 4'b0010);
      check_eq("t3_hold_data", out_data, 5'h01);
    end
    drive(4'b0000, 1'b0, '0, 1'b1);
    tick("t3");
    check_eq("t3_idle", out_valid, 1'b0);

    // Seed captured during a stall, applied on accept; zero seed in idle.
    do_reset();
    drive(4'b0001, 1'b0, '0, 1'b0);
    tick("t4");
    drive(4'b0001, 1'b1, 5'h0b, 1'b0);
    tick("t4");
    check_eq("t4_pend", seed_pending, 1'b1);
    check_eq("t4_data_held", out_data, 5'h01);
    drive(4'b0001, 1'b0, '0, 1'b1);
    tick("t4");
    check_eq("t4_new_data", out_data, 5'h0b);
    check_eq("t4_pend_clr", seed_pending, 1'b0);
    drive(4'b0000, 1'b0, '0, 1'b1);
    tick("t4");
    drive(4'b0000, 1'b1, 5'h00, 1'b0);
    tick("t4");
    drive(4'b0001, 1'b0, '0, 1'b0);
    tick("t4");
    check_eq("t4_zero_seed", out_data, 5'h01);

    // Seed write coinciding with accept loads directly.
    do_reset();
    drive(4'b0001, 1'b0, '0, 1'b0);
    tick("t5");
    drive(4'b0001, 1'b1, 5'h16, 1'b1);
    tick("t5");
    check_eq("t5_data", out_data, 5'h16);
    check_eq("t5_pend", seed_pending, 1'b0);

    // Full period from seed 01: wrap flagged after the 31st accept only.
    do_reset();
    drive(4'b0000, 1'b1, 5'h01, 1'b0);
    tick("t6");
    drive(4'b0001, 1'b0, '0, 1'b1);
    tick("t6");
    wraps = 0;
    for (int a = 1; a <= Period; a++) begin
      tick("t6");
      if (wrap_pulse) wraps++;
      if (a == Period) check_eq("t6_wrap_at_31", wrap_pulse, WrapEn);
    end
    drive(4'b0000, 1'b0, '0, 1'b1);
    tick("t6");
    if (wrap_pulse) wraps++;
    check_eq("t6_wrap_count", wraps, WrapEn ? 1 : 0);

    // Randomised traffic against the model, with occasional mid-run resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 7) == 0) ? 5'h00 : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) != 0));
      tick("rnd");
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
